// File: rtl/mux_arbiter.sv
// mux_arbiter: two-source, packet-locked round-robin arbiter in front of a
// shared SIZE-bit 2:1 mux, with a one-entry registered output stage.
//
// Handshake: a beat moves on a source port when reqX_valid && reqX_ready at a
// rising clock edge, and on the output port when out_valid && out_ready at a
// rising edge. reqX_ready depends only on registered state (never on
// reqX_valid); out_valid/out_data/out_last stay stable while out_ready is low.
module mux_arbiter #(
  parameter int SIZE      = 5,
  parameter int MAX_BEATS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req1_valid,
  input  logic [SIZE-1:0] req1_data,
  input  logic            req1_last,
  output logic            req1_ready,
  input  logic            req2_valid,
  input  logic [SIZE-1:0] req2_data,
  input  logic            req2_last,
  output logic            req2_ready,
  output logic            sel,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            overrun
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            pri_is1;     // 1: requester 1 wins a tie, 0: requester 2
  logic [CW-1:0]   beat_cnt;
  logic            space;
  logic            accept;
  logic            cur_last;
  logic            forced;
  logic            grant_end;
  logic [SIZE-1:0] mux_out;

  // Datapath mux and beat-accept decode for the current grant.
  always_comb begin
    mux_out    = sel ? req1_data : req2_data;
    space      = !out_valid || out_ready;
    req1_ready = (state == GRANT1) && space;
    req2_ready = (state == GRANT2) && space;
    accept     = ((state == GRANT1) && req1_valid) ||
                 ((state == GRANT2) && req2_valid);
    accept     = accept && space;
    cur_last   = (state == GRANT1) ? req1_last : req2_last;
    // Cap the grant: the MAX_BEATS-th beat closes it even without last.
    forced     = (beat_cnt == CW'(MAX_BEATS - 1)) && !cur_last;
    grant_end  = accept && (cur_last || forced);
  end

  // Next-state logic: round-robin pick in IDLE, hold grant until packet end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req1_valid && (pri_is1 || !req2_valid)) begin
          state_next = GRANT1;
        end else if (req2_valid) begin
          state_next = GRANT2;
        end
      end
      GRANT1, GRANT2: begin
        if (grant_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority pointer, mux select, output stage, beat counter and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_is1   <= 1'b1;
      sel       <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      // Select only changes when a new grant starts; it holds through IDLE.
      if (state == IDLE && state_next == GRANT1) begin
        pri_is1 <= 1'b0;
        sel     <= 1'b1;
      end else if (state == IDLE && state_next == GRANT2) begin
        pri_is1 <= 1'b1;
        sel     <= 1'b0;
      end
      if (accept) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
        out_last  <= cur_last || forced;
        beat_cnt  <= grant_end ? '0 : beat_cnt + CW'(1);
        if (forced) begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester, packet-locked round-robin arbiter that shares a single SIZE-bit 2:1 datapath mux (op1/op2/sig, sig=1 passes op1) between two valid/ready sources. It drives the mux select and registers the selected beat into a one-entry output stage toward a single downstream consumer. A grant is held for a whole packet, bounded by MAX_BEATS. It sits in front of any shared downstream sink that has only one input port.

## Interface
- SIZE, 5, data width of each requester and of the output
- MAX_BEATS, 8, maximum beats per grant; must be ≥1
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req1_valid  input  1  requester 1 beat valid
- req1_data  input  SIZE  requester 1 beat data (mux op1)
- req1_last  input  1  requester 1 final beat of packet
- req1_ready  output  1  requester 1 beat accepted this cycle when high with req1_valid
- req2_valid / req2_data / req2_last / req2_ready  same as requester 1; req2_data drives mux op2
- sel  output  1  mux select; 1 = requester 1, 0 = requester 2
- out_valid  output  1  registered output beat valid
- out_data  output  SIZE  registered output data
- out_last  output  1  registered last flag
- out_ready  input  1  downstream accepts out beat when high with out_valid
- overrun  output  1  sticky: a grant was force-terminated at MAX_BEATS

## Operation
- States: IDLE, GRANT1, GRANT2. Round-robin pointer pri (1 or 2).
- IDLE: both valid → grant pri; only one valid → grant that one; none → stay. On any grant, pri ← the other requester.
- space = !out_valid || out_ready. reqX_ready = (state==GRANTX) && space. This is combinational from registers only; it has no dependence on reqX_valid.
- Beat accept (GRANTX, reqX_valid, space): out_data ← mux output (sel selects X), out_valid ← 1, out_last ← reqX_last || forced, beat_cnt ← beat_cnt+1.
- forced = (beat_cnt == MAX_BEATS-1) && !reqX_last. When forced: overrun ← 1 and the grant ends. The remaining beats of the source's packet are arbitrated as a new packet.
- Grant ends on an accepted beat with out_last=1. The state then goes to IDLE and beat_cnt ← 0.
- If no beat is accepted, out_valid && out_ready clears out_valid.
- sel = 1 in GRANT1, 0 in GRANT2. In IDLE, sel holds its previous value.
- beat_cnt width = clog2(MAX_BEATS+1).

## Timing
- Reset values: state IDLE, pri=1, sel=1, out_valid=0, out_data=0, out_last=0, overrun=0, beat_cnt=0. req1_ready=req2_ready=0.
- Reset mid-packet: all state is discarded on the next edge, including an undelivered out beat. The requester sees ready=0 from the following cycle.
- Latency: request in IDLE at cycle 0 → GRANT at cycle 1 (ready high if space) → out_valid at cycle 2.
- Exactly one IDLE cycle (bubble) follows every grant end, even if both sources are waiting.
- Full throughput within a grant: one beat per cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 → ready=0 and out_data/out_last are held stable.
- A source deasserting valid mid-packet keeps the grant, with no timeout.
- MAX_BEATS=1: every beat has out_last=1. overrun sets on any beat with reqX_last=0.
- Simultaneous out drain and new accept in the same cycle: out_valid stays 1 and the data is replaced.

## Test plan
- Reset/idle: assert rst 2 cycles with random inputs → all outputs at reset values, sel=1, no ready asserted.
- Single source: req2 sends a 3-beat packet 0x03,0x04,0x05 (last on the 3rd) with out_ready=1 → sel=0 from cycle 1, out beats on cycles 2-4 with out_last only on 0x05, IDLE on cycle 4.
- Round-robin: both sources continuously send 2-beat packets (req1 0x11,0x12 / req2 0x1A,0x1B) → output order req1,req2,req1,req2…; starts with req1 after reset; one bubble cycle between packets.
- Backpressure: hold out_ready=0 for 3 cycles mid-packet → out_data stable, reqX_ready=0, no beat lost or duplicated after release.
- Overrun: MAX_BEATS=4, req1 sends a 6-beat packet → beat 4 has out_last=1 and overrun=1 (sticky). If req2 is waiting, it is granted next, then req1's beats 5-6 follow as a new packet.
- Reset mid-packet: rst during beat 2 of a 4-beat packet with out_valid=1 → out_valid=0, state IDLE, pri=1 on the next cycle.
